pipe_fetch_unit: RTL and testbench
==================================

// Module: pipe_fetch_unit
// PURPOSE
// IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Feeds dpc4/inst to the ID stage and consumes
// ID's next-PC controls (pcsource, bpc, jpc, da) and load-use stall (wpcir), honouring one branch delay slot.
// Fetches from a variable-latency instruction memory over a req/ack handshake with one outstanding request.
// PARAMETERS
// RESET_PC  32'h0000_0000  PC loaded on reset
// NOP_INST  32'h0000_0000  instruction word placed in IF/ID when a bubble is inserted (sll $0,$0,0)
// PORTS
// clock       in   1   pipeline clock, all state updates on rising edge
// resetn      in   1   asynchronous active-low reset
// pcsource    in   2   from ID: 00 pc+4, 01 bpc (branch), 10 da (jr), 11 jpc (j/jal)
// bpc         in   32  from ID: branch target
// jpc         in   32  from ID: jump target
// da          in   32  from ID: forwarded rs value, jr target
// wpcir       in   1   from ID: 1 = load-use stall, hold PC and IF/ID register
// imem_req    out  1   fetch request, address valid
// imem_addr   out  32  fetch address (= pc)
// imem_ack    in   1   fetch complete, imem_rdata valid this cycle; may arrive in the req cycle
// imem_rdata  in   32  fetched instruction
// pc          out  32  address of the instruction currently in IF
// dpc4        out  32  IF/ID: address of ID instruction + 4
// inst        out  32  IF/ID: instruction in ID
// ivalid      out  1   IF/ID: 1 = real instruction, 0 = bubble (inst = NOP_INST)
// BEHAVIOUR
// - Reset (async, resetn=0): pc=RESET_PC, dpc4=0, inst=NOP_INST, ivalid=0, state=FETCH, buffer empty,
//   redir_v=0, imem_req=0. Mid-fetch reset abandons the request; memory shares the same reset.
// - States: FETCH (imem_req=1, imem_addr=pc, waiting for ack); HOLD (ack received, word in buffer, imem_req=0).
//   imem_addr stays stable while imem_req=1 and imem_ack=0. First request in the first cycle after resetn rises.
// - avail = (FETCH & imem_ack) | HOLD; word = HOLD ? buffer : imem_rdata.
// - xfer = avail & ~wpcir. On xfer: inst<=word, dpc4<=pc+4, ivalid<=1, state<=FETCH, redir_v<=0,
//   pc<=npc where npc = redir_v ? redir_pc : mux(pcsource: pc+4, bpc, da, jpc).
// - FETCH & imem_ack & wpcir: buffer<=imem_rdata, state<=HOLD; pc and IF/ID unchanged.
// - ~avail & ~wpcir: IF/ID loads bubble (inst<=NOP_INST, ivalid<=0, dpc4 unchanged); pc unchanged.
// - wpcir=1: IF/ID and pc hold regardless of anything else; in FETCH the request continues.
// - Delay slot: the pc update happens only on xfer, i.e. while the branch/jump leaves ID, so the word
//   transferred is the delay slot at pc and npc is the instruction after it.
// - Redirect capture: if ivalid & ~wpcir & ~xfer & pcsource!=00 (branch leaves ID while delay-slot fetch is pending),
//   redir_pc<=mux(pcsource), redir_v<=1. redir_v has priority at the next xfer; ID then holds a bubble (pcsource=00).
// - Arithmetic: pc+4 is 32-bit modulo (0xFFFF_FFFC wraps to 0). No alignment check; low 2 bits pass through.
// - No combinational path from imem_ack/imem_rdata to any registered output except via the clock edge.
// TESTING
// 1 Reset: resetn=0 mid-FETCH -> pc=0, ivalid=0, inst=0, imem_req=0 at once; release -> imem_req=1, imem_addr=0.
// 2 Zero-wait: ack=1 always, rdata=addr|0x1000_0000 -> IF/ID gets 0x1000_0000/dpc4=4, then 0x1000_0004/dpc4=8, one per cycle.
// 3 Stall: ack at pc=0x8 with wpcir=1 for 2 cycles -> HOLD, req=0, IF/ID frozen; wpcir=0 -> inst=buffered word, dpc4=0xC.
// 4 Taken beq at 0x8 (pcsource=01, bpc=0x40), zero-wait -> ID gets delay slot 0xC (dpc4=0x10), next imem_addr=0x40.
// 5 Same beq, delay-slot ack after 3 cycles -> ID bubbles (ivalid=0, inst=0), redir_v=1; after ack pc=0x40, never 0x10.
// 6 jr (pcsource=10, da=0x100) then jal (pcsource=11, jpc=0x200) -> fetch addresses 0x100.., then 0x200 after each delay slot.

Source files
------------

// File: rtl/pipe_fetch_unit.sv
// IF stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Fetches over a one-outstanding req/ack handshake and honours one branch delay slot.
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        ivalid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_v_q, redir_v_d;

  logic        req, avail, xfer;
  logic [31:0] word, pc4, npc_sel, npc;

  // run_q keeps the request low until the first edge after reset releases
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_q      <= 1'b0;
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      dpc4_q     <= '0;
      inst_q     <= NOP_INST;
      ivalid_q   <= 1'b0;
      buf_q      <= '0;
      redir_pc_q <= '0;
      redir_v_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      state_q    <= state_d;
      pc_q       <= pc_d;
      dpc4_q     <= dpc4_d;
      inst_q     <= inst_d;
      ivalid_q   <= ivalid_d;
      buf_q      <= buf_d;
      redir_pc_q <= redir_pc_d;
      redir_v_q  <= redir_v_d;
    end
  end

  always_comb begin
    req   = run_q && (state_q == FETCH);
    avail = (req && imem_ack) || (state_q == HOLD);
    xfer  = avail && !wpcir;
    word  = (state_q == HOLD) ? buf_q : imem_rdata;
    pc4   = pc_q + 32'd4;

    unique case (pcsource)
      2'b01:   npc_sel = bpc;
      2'b10:   npc_sel = da;
      2'b11:   npc_sel = jpc;
      default: npc_sel = pc4;
    endcase
    npc = redir_v_q ? redir_pc_q : npc_sel;

    state_d    = state_q;
    pc_d       = pc_q;
    dpc4_d     = dpc4_q;
    inst_d     = inst_q;
    ivalid_d   = ivalid_q;
    buf_d      = buf_q;
    redir_pc_d = redir_pc_q;
    redir_v_d  = redir_v_q;

    if (xfer) begin
      inst_d    = word;
      dpc4_d    = pc4;
      ivalid_d  = 1'b1;
      state_d   = FETCH;
      redir_v_d = 1'b0;
      pc_d      = npc;
    end else if (req && imem_ack && wpcir) begin
      buf_d   = imem_rdata;
      state_d = HOLD;
    end else if (!avail && !wpcir) begin
      inst_d   = NOP_INST;
      ivalid_d = 1'b0;
    end

    // A branch leaving ID before its delay slot arrives must remember its target
    if (ivalid_q && !wpcir && !xfer && (pcsource != 2'b00)) begin
      redir_pc_d = npc_sel;
      redir_v_d  = 1'b1;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dpc4      = dpc4_q;
  assign inst      = inst_q;
  assign ivalid    = ivalid_q;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed self-checking bench for pipe_fetch_unit; the bench plays both
// instruction memory (rdata = addr | 0x1000_0000) and the ID stage.
module tb_pipe_fetch_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0;
  logic [31:0] jpc = '0;
  logic [31:0] da = '0;
  logic        wpcir = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, inst;
  logic        ivalid;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pcsource  (pcsource),
    .bpc       (bpc),
    .jpc       (jpc),
    .da        (da),
    .wpcir     (wpcir),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .dpc4      (dpc4),
    .inst      (inst),
    .ivalid    (ivalid)
  );

  always #5 clock = ~clock;

  // Non-acked cycles return garbage so a buffered word is distinguishable
  assign imem_rdata = imem_ack ? (imem_addr | 32'h1000_0000) : 32'hDEAD_BEEF;

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    imem_ack = 1'b0;
    wpcir    = 1'b0;
    pcsource = 2'b00;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_first_req: req=%b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    cyc();
    cyc();
    #2;
    imem_ack = 1'b0;
    resetn   = 1'b0;
    #1;
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_pc: got %h want 00000000", pc);
    end
    n_checks++;
    if (ivalid !== 1'b0 || inst !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ifid: ivalid=%b inst=%h, want 0/00000000", ivalid, inst);
    end
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req: got %b want 0", imem_req);
    end
    #2;
    resetn = 1'b1;
    cyc();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_release: req=%b addr=%h, want 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait;
    imem_ack = 1'b1;
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0000 || dpc4 !== 32'h4 || ivalid !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_first: inst=%h dpc4=%h ivalid=%b, want 10000000/00000004/1", inst, dpc4, ivalid);
    end
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0004 || dpc4 !== 32'h8) begin
      n_fail++;
      $display("FAIL zw_second: inst=%h dpc4=%h, want 10000004/00000008", inst, dpc4);
    end
    n_checks++;
    if (pc !== 32'h8) begin
      n_fail++;
      $display("FAIL zw_pc: got %h want 00000008", pc);
    end
  endtask

  task automatic test_stall;
    wpcir    = 1'b1;
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req1: got %b want 0", imem_req);
    end
    n_checks++;
    if (inst !== 32'h1000_0004 || dpc4 !== 32'h8 || pc !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_frozen1: inst=%h dpc4=%h pc=%h, want 10000004/00000008/00000008", inst, dpc4, pc);
    end
    cyc();
    n_checks++;
    if (imem_req !== 1'b0 || inst !== 32'h1000_0004 || ivalid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_frozen2: req=%b inst=%h ivalid=%b, want 0/10000004/1", imem_req, inst, ivalid);
    end
    wpcir = 1'b0;
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0008 || dpc4 !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_release: inst=%h dpc4=%h, want 10000008/0000000c", inst, dpc4);
    end
    n_checks++;
    if (pc !== 32'hC || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_refetch: pc=%h req=%b, want 0000000c/1", pc, imem_req);
    end
  endtask

  task automatic test_branch_zero_wait;
    do_reset();
    imem_ack = 1'b1;
    cyc();
    cyc();
    cyc();
    pcsource = 2'b01;
    bpc      = 32'h40;
    cyc();
    pcsource = 2'b00;
    n_checks++;
    if (inst !== 32'h1000_000C || dpc4 !== 32'h10) begin
      n_fail++;
      $display("FAIL br0_slot: inst=%h dpc4=%h, want 1000000c/00000010", inst, dpc4);
    end
    n_checks++;
    if (imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL br0_target: addr=%h want 00000040", imem_addr);
    end
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0040 || dpc4 !== 32'h44) begin
      n_fail++;
      $display("FAIL br0_after: inst=%h dpc4=%h, want 10000040/00000044", inst, dpc4);
    end
  endtask

  task automatic test_branch_wait;
    do_reset();
    imem_ack = 1'b1;
    cyc();
    cyc();
    cyc();
    imem_ack = 1'b0;
    pcsource = 2'b01;
    bpc      = 32'h40;
    cyc();
    pcsource = 2'b00;
    n_checks++;
    if (ivalid !== 1'b0 || inst !== 32'h0) begin
      n_fail++;
      $display("FAIL brw_bubble: ivalid=%b inst=%h, want 0/00000000", ivalid, inst);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL brw_pending: req=%b addr=%h, want 1/0000000c", imem_req, imem_addr);
    end
    cyc();
    n_checks++;
    if (pc !== 32'hC || ivalid !== 1'b0) begin
      n_fail++;
      $display("FAIL brw_wait: pc=%h ivalid=%b, want 0000000c/0", pc, ivalid);
    end
    imem_ack = 1'b1;
    cyc();
    n_checks++;
    if (inst !== 32'h1000_000C || dpc4 !== 32'h10 || ivalid !== 1'b1) begin
      n_fail++;
      $display("FAIL brw_slot: inst=%h dpc4=%h ivalid=%b, want 1000000c/00000010/1", inst, dpc4, ivalid);
    end
    n_checks++;
    if (pc !== 32'h40) begin
      n_fail++;
      $display("FAIL brw_redirect: pc=%h want 00000040", pc);
    end
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0040 || pc !== 32'h44) begin
      n_fail++;
      $display("FAIL brw_after: inst=%h pc=%h, want 10000040/00000044", inst, pc);
    end
  endtask

  task automatic test_jr_jal;
    do_reset();
    imem_ack = 1'b1;
    cyc();
    pcsource = 2'b10;
    da       = 32'h100;
    cyc();
    pcsource = 2'b00;
    n_checks++;
    if (inst !== 32'h1000_0004 || dpc4 !== 32'h8 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL jr_slot: inst=%h dpc4=%h addr=%h, want 10000004/00000008/00000100", inst, dpc4, imem_addr);
    end
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0100 || imem_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL jr_target: inst=%h addr=%h, want 10000100/00000104", inst, imem_addr);
    end
    pcsource = 2'b11;
    jpc      = 32'h200;
    cyc();
    pcsource = 2'b00;
    n_checks++;
    if (inst !== 32'h1000_0104 || dpc4 !== 32'h108 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL jal_slot: inst=%h dpc4=%h addr=%h, want 10000104/00000108/00000200", inst, dpc4, imem_addr);
    end
    cyc();
    n_checks++;
    if (inst !== 32'h1000_0200 || dpc4 !== 32'h204) begin
      n_fail++;
      $display("FAIL jal_target: inst=%h dpc4=%h, want 10000200/00000204", inst, dpc4);
    end
  endtask

  task automatic test_wrap;
    pcsource = 2'b10;
    da       = 32'hFFFF_FFFC;
    cyc();
    pcsource = 2'b00;
    n_checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_jump: pc=%h want fffffffc", pc);
    end
    cyc();
    n_checks++;
    if (inst !== 32'hFFFF_FFFC || dpc4 !== 32'h0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc4: inst=%h dpc4=%h pc=%h, want fffffffc/00000000/00000000", inst, dpc4, pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch_zero_wait();
    test_branch_wait();
    test_jr_jal();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
